// File: rtl/fiapp_checker_if.sv
// Stimulus, observed-output and status bundle between a fiapp lockstep
// checker and whatever drives it.
interface fiapp_checker_if #(
    parameter int CNT_W = 32,
    parameter int ERR_W = 16
);
    logic             clear;
    logic             dut_reset;
    logic             a;
    logic             enable;
    logic             o1;
    logic             o2;
    logic             o3;
    logic             checking;
    logic             fault_flag;
    logic [2:0]       fault_vec;
    logic [CNT_W-1:0] fault_cycle;
    logic [ERR_W-1:0] err_count;

    modport master (
        output clear, dut_reset, a, enable, o1, o2, o3,
        input  checking, fault_flag, fault_vec, fault_cycle, err_count
    );

    modport slave (
        input  clear, dut_reset, a, enable, o1, o2, o3,
        output checking, fault_flag, fault_vec, fault_cycle, err_count
    );
endinterface

// File: rtl/fiapp_checker.sv
// Lockstep checker for fiapp: shadow register model, per-cycle output compare,
// sticky first-fault capture and saturating mismatch count.
module fiapp_checker #(
    parameter int EXT_W = 65,
    parameter int CNT_W = 32,
    parameter int ERR_W = 16
) (
    input  logic           clk,
    input  logic           reset,
    fiapp_checker_if.slave bus
);

    typedef enum logic [1:0] {
        WAIT_RST = 2'd0,
        SYNC     = 2'd1,
        CHECK    = 2'd2,
        FAULT    = 2'd3
    } state_t;

    state_t             state_q;
    logic               q1_q;
    logic               q2_q;
    logic               q3_q;
    logic [EXT_W-1:0]   qext_q;
    logic [CNT_W-1:0]   cyc_cnt_q;
    logic               checking_q;
    logic               fault_flag_q;
    logic [2:0]         fault_vec_q;
    logic [CNT_W-1:0]   fault_cycle_q;
    logic [ERR_W-1:0]   err_count_q;
    logic               e3_s;
    logic [2:0]         mism_s;

    function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    function automatic logic [ERR_W-1:0] sat_inc_err(input logic [ERR_W-1:0] v);
        return (&v) ? v : v + {{(ERR_W-1){1'b0}}, 1'b1};
    endfunction

    // Expected outputs from the shadow and per-bit mismatch against observed.
    always_comb begin
        e3_s   = q3_q & qext_q[EXT_W-1];
        mism_s = {bus.o3 ^ e3_s, bus.o2 ^ q2_q, bus.o1 ^ q1_q};
    end

    // Shadow copy of the fiapp register model; runs in every state so it stays aligned.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q1_q   <= 1'b0;
            q2_q   <= 1'b0;
            q3_q   <= 1'b0;
            qext_q <= {EXT_W{1'b0}};
        end else if (bus.clear || bus.dut_reset) begin
            q1_q   <= 1'b0;
            q2_q   <= 1'b0;
            q3_q   <= 1'b0;
            qext_q <= {EXT_W{1'b0}};
        end else begin
            if (bus.enable) begin
                q1_q <= bus.a;
            end else begin
                q1_q <= q1_q;
            end
            q2_q   <= q1_q;
            q3_q   <= ~q1_q;
            qext_q <= qext_q + {{(EXT_W-1){1'b0}}, 1'b1};
        end
    end

    // Checker FSM with compare-cycle counter and sticky fault capture.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= WAIT_RST;
            cyc_cnt_q     <= {CNT_W{1'b0}};
            checking_q    <= 1'b0;
            fault_flag_q  <= 1'b0;
            fault_vec_q   <= 3'b000;
            fault_cycle_q <= {CNT_W{1'b0}};
            err_count_q   <= {ERR_W{1'b0}};
        end else if (bus.clear) begin
            state_q       <= WAIT_RST;
            cyc_cnt_q     <= {CNT_W{1'b0}};
            checking_q    <= 1'b0;
            fault_flag_q  <= 1'b0;
            fault_vec_q   <= 3'b000;
            fault_cycle_q <= {CNT_W{1'b0}};
            err_count_q   <= {ERR_W{1'b0}};
        end else begin
            case (state_q)
                WAIT_RST: begin
                    if (bus.dut_reset) begin
                        state_q <= SYNC;
                    end else begin
                        state_q <= WAIT_RST;
                    end
                end
                SYNC: begin
                    cyc_cnt_q <= {CNT_W{1'b0}};
                    if (!bus.dut_reset) begin
                        state_q    <= CHECK;
                        checking_q <= 1'b1;
                    end else begin
                        state_q <= SYNC;
                    end
                end
                CHECK: begin
                    if (bus.dut_reset) begin
                        state_q    <= SYNC;
                        checking_q <= 1'b0;
                        cyc_cnt_q  <= {CNT_W{1'b0}};
                    end else begin
                        cyc_cnt_q <= sat_inc_cnt(cyc_cnt_q);
                        if (|mism_s) begin
                            state_q       <= FAULT;
                            fault_flag_q  <= 1'b1;
                            fault_vec_q   <= mism_s;
                            fault_cycle_q <= cyc_cnt_q;
                            err_count_q   <= sat_inc_err(err_count_q);
                        end else begin
                            state_q <= CHECK;
                        end
                    end
                end
                FAULT: begin
                    // Sticky: only the error count keeps moving; dut_reset just pauses compares.
                    state_q <= FAULT;
                    if (!bus.dut_reset) begin
                        cyc_cnt_q <= sat_inc_cnt(cyc_cnt_q);
                        if (|mism_s) begin
                            err_count_q <= sat_inc_err(err_count_q);
                        end else begin
                            err_count_q <= err_count_q;
                        end
                    end else begin
                        cyc_cnt_q <= cyc_cnt_q;
                    end
                end
                default: begin
                    state_q    <= WAIT_RST;
                    checking_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.checking    = checking_q;
    assign bus.fault_flag  = fault_flag_q;
    assign bus.fault_vec   = fault_vec_q;
    assign bus.fault_cycle = fault_cycle_q;
    assign bus.err_count   = err_count_q;

endmodule

// File: tb/tb_fiapp_checker.sv
// Self-checking bench: two checker instances (default widths, and EXT_W=4/ERR_W=2)
// watch a behavioural fiapp model with programmable output faults.
module tb_fiapp_checker;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic       clear_s     = 1'b0;
    logic       dut_reset_s = 1'b0;
    logic       a_s         = 1'b0;
    logic       en_s        = 1'b0;
    logic [2:0] inv0 = 3'b000, stk_en0 = 3'b000, stk_val0 = 3'b000;
    logic [2:0] inv1 = 3'b000, stk_en1 = 3'b000, stk_val1 = 3'b000;

    int tests_run    = 0;
    int tests_failed = 0;

    fiapp_checker_if #(.CNT_W(32), .ERR_W(16)) bus0 ();
    fiapp_checker_if #(.CNT_W(32), .ERR_W(2))  bus1 ();

    fiapp_checker #(.EXT_W(65), .CNT_W(32), .ERR_W(16)) dut0 (
        .clk(clk), .reset(reset), .bus(bus0.slave));
    fiapp_checker #(.EXT_W(4), .CNT_W(32), .ERR_W(2)) dut1 (
        .clk(clk), .reset(reset), .bus(bus1.slave));

    // Behavioural fiapp: the unfaulted reference the checkers should agree with.
    logic        m_q1 = 1'b0, m_q2 = 1'b0, m_q3 = 1'b0;
    logic [64:0] m_x0 = '0;
    logic [3:0]  m_x1 = '0;
    always @(posedge clk) begin
        if (dut_reset_s) begin
            m_q1 <= 1'b0; m_q2 <= 1'b0; m_q3 <= 1'b0;
            m_x0 <= '0;   m_x1 <= '0;
        end else begin
            if (en_s) m_q1 <= a_s;
            m_q2 <= m_q1;
            m_q3 <= !m_q1;
            m_x0 <= m_x0 + 65'd1;
            m_x1 <= m_x1 + 4'd1;
        end
    end

    logic [2:0] g0, g1, obs0, obs1;
    assign g0   = {m_q3 & m_x0[64], m_q2, m_q1};
    assign g1   = {m_q3 & m_x1[3],  m_q2, m_q1};
    assign obs0 = ((g0 ^ inv0) & ~stk_en0) | (stk_val0 & stk_en0);
    assign obs1 = ((g1 ^ inv1) & ~stk_en1) | (stk_val1 & stk_en1);

    assign bus0.clear = clear_s;  assign bus1.clear = clear_s;
    assign bus0.dut_reset = dut_reset_s;  assign bus1.dut_reset = dut_reset_s;
    assign bus0.a = a_s;  assign bus1.a = a_s;
    assign bus0.enable = en_s;  assign bus1.enable = en_s;
    assign bus0.o1 = obs0[0];  assign bus0.o2 = obs0[1];  assign bus0.o3 = obs0[2];
    assign bus1.o1 = obs1[0];  assign bus1.o2 = obs1[1];  assign bus1.o3 = obs1[2];

    typedef struct {
        int          which;
        string       tag;
        logic        chk;
        logic        ff;
        logic [2:0]  fv;
        logic [31:0] fc;
        logic [15:0] ec;
    } exp_t;
    exp_t sb[$];

    task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input int which, input string tag, input logic chk, input logic ff,
                            input logic [2:0] fv, input logic [31:0] fc, input logic [15:0] ec);
        exp_t e;
        e.which = which; e.tag = tag; e.chk = chk; e.ff = ff;
        e.fv = fv; e.fc = fc; e.ec = ec;
        sb.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.which == 0) begin
                chk_eq({e.tag, ".d0.checking"}, 64'(bus0.checking),    64'(e.chk));
                chk_eq({e.tag, ".d0.flag"},     64'(bus0.fault_flag),  64'(e.ff));
                chk_eq({e.tag, ".d0.vec"},      64'(bus0.fault_vec),   64'(e.fv));
                chk_eq({e.tag, ".d0.cycle"},    64'(bus0.fault_cycle), 64'(e.fc));
                chk_eq({e.tag, ".d0.errs"},     64'(bus0.err_count),   64'(e.ec));
            end else begin
                chk_eq({e.tag, ".d1.checking"}, 64'(bus1.checking),    64'(e.chk));
                chk_eq({e.tag, ".d1.flag"},     64'(bus1.fault_flag),  64'(e.ff));
                chk_eq({e.tag, ".d1.vec"},      64'(bus1.fault_vec),   64'(e.fv));
                chk_eq({e.tag, ".d1.cycle"},    64'(bus1.fault_cycle), 64'(e.fc));
                chk_eq({e.tag, ".d1.errs"},     64'(bus1.err_count),   64'(e.ec));
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_zero(input string tag);
        push_exp(0, tag, 1'b0, 1'b0, 3'b000, 32'd0, 16'd0);
        push_exp(1, tag, 1'b0, 1'b0, 3'b000, 32'd0, 16'd0);
    endtask

    task automatic push_ok(input int which, input string tag);
        push_exp(which, tag, 1'b1, 1'b0, 3'b000, 32'd0, 16'd0);
    endtask

    // Two-cycle dut_reset pulse then release: next edge is compare cycle 0.
    task automatic arm();
        dut_reset_s = 1'b1;
        tick();
        tick();
        dut_reset_s = 1'b0;
        push_ok(0, "arm");
        push_ok(1, "arm");
        tick();
        drain();
    endtask

    task automatic clear_pulse();
        clear_s = 1'b1;
        push_zero("clr");
        tick();
        drain();
        clear_s = 1'b0;
    endtask

    initial begin
        int first_k;
        int nerr;
        logic hit;

        reset = 1'b0;
        repeat (3) tick();
        push_zero("rst");
        drain();
        reset = 1'b1;
        tick();
        push_zero("idle");
        tick();
        drain();

        // Healthy run
        a_s = 1'b1; en_s = 1'b1;
        arm();
        for (int k = 0; k < 30; k++) begin
            push_ok(0, "healthy");
            push_ok(1, "healthy");
            tick();
            drain();
        end
        clear_pulse();
        for (int k = 0; k < 3; k++) begin
            push_zero("noarm");
            tick();
            drain();
        end

        // Transient o2 flip on compare cycle 5
        arm();
        for (int k = 0; k < 16; k++) begin
            inv0 = (k == 5) ? 3'b010 : 3'b000;
            push_exp(0, "transient", 1'b1, k >= 5, (k >= 5) ? 3'b010 : 3'b000,
                     (k >= 5) ? 32'd5 : 32'd0, (k >= 5) ? 16'd1 : 16'd0);
            push_ok(1, "transient");
            tick();
            drain();
        end
        inv0 = 3'b000;
        clear_pulse();

        // o1 stuck at 1 from compare cycle 3 with a=0
        a_s = 1'b0; en_s = 1'b1;
        stk_val0 = 3'b001;
        arm();
        for (int k = 0; k < 12; k++) begin
            stk_en0 = (k >= 3) ? 3'b001 : 3'b000;
            push_exp(0, "stuck1", 1'b1, k >= 3, (k >= 3) ? 3'b001 : 3'b000,
                     (k >= 3) ? 32'd3 : 32'd0, (k >= 3) ? 16'(k - 2) : 16'd0);
            push_ok(1, "stuck1");
            tick();
            drain();
        end
        stk_en0 = 3'b000;
        clear_pulse();

        // Narrow qext: o3 held low, mismatch once the model's qext MSB rises; ERR_W=2 saturates
        stk_en1 = 3'b100; stk_val1 = 3'b000;
        arm();
        first_k = -1;
        for (int k = 0; k < 12; k++) begin
            if (first_k < 0 && g1[2]) first_k = k;
            hit  = (first_k >= 0);
            nerr = hit ? (k - first_k + 1) : 0;
            push_exp(1, "ext4", 1'b1, hit, hit ? 3'b100 : 3'b000,
                     hit ? 32'(first_k) : 32'd0, (nerr > 3) ? 16'd3 : 16'(nerr));
            push_ok(0, "ext4");
            tick();
            drain();
        end
        stk_en1 = 3'b000;
        // Clear wins over a simultaneous dut_reset, which is then seen again
        clear_s = 1'b1; dut_reset_s = 1'b1;
        push_zero("clr_rst");
        tick();
        drain();
        clear_s = 1'b0;
        push_zero("resync");
        tick();
        drain();
        dut_reset_s = 1'b0;
        push_ok(0, "rearm");
        push_ok(1, "rearm");
        tick();
        drain();
        clear_pulse();

        // dut_reset mid-check: no compare in the window, cycle index restarts at 0
        a_s = 1'b1; en_s = 1'b1;
        arm();
        for (int k = 0; k < 10; k++) begin
            push_ok(0, "pre_rst");
            tick();
            drain();
        end
        dut_reset_s = 1'b1;
        inv0 = 3'b100;
        for (int k = 0; k < 3; k++) begin
            push_exp(0, "rst_win", 1'b0, 1'b0, 3'b000, 32'd0, 16'd0);
            tick();
            drain();
        end
        inv0 = 3'b000;
        dut_reset_s = 1'b0;
        push_ok(0, "rst_rel");
        tick();
        drain();
        for (int k = 0; k < 5; k++) begin
            inv0 = (k == 2) ? 3'b001 : 3'b000;
            push_exp(0, "restart", 1'b1, k >= 2, (k >= 2) ? 3'b001 : 3'b000,
                     (k >= 2) ? 32'd2 : 32'd0, (k >= 2) ? 16'd1 : 16'd0);
            tick();
            drain();
        end
        inv0 = 3'b000;

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
